// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register scoreboard with hazard stall, flush FSM and stall counter
module issue_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_i,
  input  logic [4:0]       rs1_address_i,
  input  logic [4:0]       rs2_address_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic [4:0]       rd_address_i,
  input  logic             rd_write_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [31:0]      pending_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [31:0]      pending_q;
  logic [31:0]      pending_d;
  logic [31:0]      wb_mask;
  logic [31:0]      set_mask;
  logic [31:0]      visible;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             hazard;
  logic             accept;

  // Writeback bypass: a register retiring this cycle no longer blocks issue.
  always_comb begin
    wb_mask = '0;
    if (wb_valid_i) wb_mask[wb_rd_i] = 1'b1;
    visible = pending_q & ~wb_mask;
    hazard  = issue_valid_i &
              ((rs1_used_i & visible[rs1_address_i]) |
               (rs2_used_i & visible[rs2_address_i]) |
               (rd_write_i & visible[rd_address_i]));
  end

  // Compute the next pending vector; set beats same-cycle clear, flush beats both.
  always_comb begin
    accept   = issue_valid_i & ~stall_o;
    set_mask = '0;
    if (accept && rd_write_i) set_mask[rd_address_i] = 1'b1;
    set_mask[0] = 1'b0;
    if (flush_i) pending_d = '0;
    else         pending_d = (pending_q & ~wb_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // Pending register; x0 is never tracked.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next state; flush overrides every transition.
  always_comb begin
    state_d = ST_RUN;
    if (flush_i) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   state_d = hazard ? ST_STALL : ST_RUN;
        ST_STALL: state_d = hazard ? ST_STALL : ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // FSM outputs; stall reacts combinationally to hazard and flush.
  always_comb begin
    stall_o = hazard | (state_q == ST_FLUSH) | flush_i;
    state_o = state_q;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles_q <= '0;
    else if (stall_o && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_q <= stall_cycles_q + 1'b1;
  end

  assign pending_o      = {pending_q[31:1], 1'b0};
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - randomized self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i;
  logic [4:0]  rs1_address_i;
  logic [4:0]  rs2_address_i;
  logic        rs1_used_i;
  logic        rs2_used_i;
  logic [4:0]  rd_address_i;
  logic        rd_write_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        stall_o, stall4_o;
  logic [31:0] pending_o, pending4_o;
  logic [1:0]  state_o, state4_o;
  logic [15:0] stall_cycles_o;
  logic [3:0]  stall_cycles4_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          mpend [32];
  int          mstate;
  int          mcnt16;
  int          mcnt4;

  always #5 clk = ~clk;

  issue_scoreboard #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .issue_valid_i(issue_valid_i),
    .rs1_address_i(rs1_address_i), .rs2_address_i(rs2_address_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_address_i(rd_address_i), .rd_write_i(rd_write_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .pending_o(pending_o), .state_o(state_o),
    .stall_cycles_o(stall_cycles_o)
  );

  issue_scoreboard #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .issue_valid_i(issue_valid_i),
    .rs1_address_i(rs1_address_i), .rs2_address_i(rs2_address_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_address_i(rd_address_i), .rd_write_i(rd_write_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
    .stall_o(stall4_o), .pending_o(pending4_o), .state_o(state4_o),
    .stall_cycles_o(stall_cycles4_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = mpend[i];
    return v;
  endfunction

  function automatic bit blocks(input int r, input bit wv, input int wr);
    return (r != 0) && mpend[r] && !(wv && wr == r);
  endfunction

  // Apply one cycle of inputs, compare against the model, then advance the model across the edge.
  task automatic step(input bit r, input bit iv, input int a1, input int a2, input bit u1,
                      input bit u2, input int rd, input bit rw, input bit wv, input int wr,
                      input bit fl);
    bit haz, stl, acc;
    rst = r; issue_valid_i = iv; rs1_address_i = 5'(a1); rs2_address_i = 5'(a2);
    rs1_used_i = u1; rs2_used_i = u2; rd_address_i = 5'(rd); rd_write_i = rw;
    wb_valid_i = wv; wb_rd_i = 5'(wr); flush_i = fl;
    #1;
    haz = iv && ((u1 && blocks(a1, wv, wr)) || (u2 && blocks(a2, wv, wr)) ||
                 (rw && blocks(rd, wv, wr)));
    stl = haz || (mstate == 2) || fl;
    acc = iv && !stl;
    check("stall", 64'(stall_o), 64'(stl));
    check("stall4", 64'(stall4_o), 64'(stl));
    check("pending", 64'(pending_o), 64'(model_vec()));
    check("state", 64'(state_o), 64'(mstate));
    check("cnt16", 64'(stall_cycles_o), 64'(mcnt16));
    check("cnt4", 64'(stall_cycles4_o), 64'(mcnt4));
    if (r) begin
      foreach (mpend[i]) mpend[i] = 0;
      mstate = 0; mcnt16 = 0; mcnt4 = 0;
    end else begin
      if (stl) begin
        if (mcnt16 < 65535) mcnt16++;
        if (mcnt4 < 15) mcnt4++;
      end
      if (fl) begin
        foreach (mpend[i]) mpend[i] = 0;
        mstate = 2;
      end else begin
        if (wv) mpend[wr] = 0;
        if (acc && rw && rd != 0) mpend[rd] = 1;
        if (mstate == 2) mstate = 0;
        else mstate = haz ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue_wr(input int rd);
    step(0, 1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
  endtask

  initial begin
    foreach (mpend[i]) mpend[i] = 0;
    mstate = 0; mcnt16 = 0; mcnt4 = 0;
    rst = 1'b1; issue_valid_i = 0; rs1_address_i = 0; rs2_address_i = 0;
    rs1_used_i = 0; rs2_used_i = 0; rd_address_i = 0; rd_write_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; flush_i = 0;
    @(posedge clk); #1;
    idle(1);
    idle(1);
    check("reset_pending", 64'(pending_o), 64'h0);
    check("reset_state", 64'(state_o), 64'd0);
    check("reset_cnt", 64'(stall_cycles_o), 64'd0);

    // RAW hazard on x5 resolved by writeback bypass
    issue_wr(5);
    check("raw_pending5", 64'(pending_o), 64'h20);
    step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    check("raw_state_stall", 64'(state_o), 64'd1);
    step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    check("raw_cnt", 64'(stall_cycles_o), 64'd2);
    step(0, 1, 5, 0, 1, 0, 0, 0, 1, 5, 0);
    check("raw_state_run", 64'(state_o), 64'd0);

    // writes to x0 are never tracked
    issue_wr(0);
    check("x0_pending", 64'(pending_o), 64'h0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // set wins over same-cycle clear
    issue_wr(7);
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    check("setwins_p7", 64'(pending_o[7]), 64'd1);

    // flush with pending x8..x11
    idle(1);
    for (int i = 8; i < 12; i++) issue_wr(i);
    check("flush_pre", 64'(pending_o), 64'h0000_0F00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("flush_state", 64'(state_o), 64'd2);
    check("flush_pending", 64'(pending_o), 64'h0);
    idle(0);
    check("flush_run", 64'(state_o), 64'd0);

    // saturation of the narrow counter
    idle(1);
    issue_wr(3);
    for (int i = 0; i < 20; i++) step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("sat_cnt4", 64'(stall_cycles4_o), 64'd15);
    check("sat_cnt16", 64'(stall_cycles_o), 64'd20);

    // reset mid-stall with every register pending
    idle(1);
    for (int i = 1; i < 32; i++) issue_wr(i);
    check("full_pending", 64'(pending_o), 64'hFFFF_FFFE);
    step(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    check("rst_pending", 64'(pending_o), 64'h0);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);

    // randomized traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(199) == 0, $urandom_range(9) < 7,
           $urandom_range(7), $urandom_range(7),
           $urandom_range(1), $urandom_range(1),
           $urandom_range(7), $urandom_range(3) != 0,
           $urandom_range(9) < 4, $urandom_range(7),
           $urandom_range(39) == 0);
    end
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
